// File: rtl/st_port_arbiter.sv
// rtl/st_port_arbiter.sv - round-robin arbiter sharing one dcache write port among NUM_REQ store requesters
//
// Purpose:
//   Picks one requester round-robin, registers its addr/data/be, and presents
//   them to the dcache write port until mem_gnt_i. The grant is then returned
//   to the winner as a one-cycle req_gnt_o pulse, in the same cycle.
//
// Ports:
//   clk_i, rst_i      clock (rising edge), synchronous active-high reset
//   req_valid_i       per-requester request
//   req_addr_i        packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data_i        packed store data
//   req_be_i          packed byte enables
//   req_gnt_o         one-cycle grant pulse to the winning requester
//   mem_req_o         request to the dcache write port
//   mem_addr_o        registered address
//   mem_data_o        registered data
//   mem_be_o          registered byte enables
//   mem_gnt_i         dcache grant; a transfer occurs on mem_req_o && mem_gnt_i
//   busy_o            high while a transfer is outstanding
//   owner_o           index of the current or last winner
//   err_o             sticky timeout flag (only with ST_ARB_TIMEOUT_EN)
//
// Optional feature:
//   ST_ARB_TIMEOUT_EN adds a watchdog. It abandons a request after
//   TIMEOUT_CYCLES ungranted cycles and sets err_o.

module st_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 34,
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  input  logic [NUM_REQ*BE_WIDTH-1:0]      req_be_i,
  output logic [NUM_REQ-1:0]               req_gnt_o,
  output logic                             mem_req_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_data_o,
  output logic [BE_WIDTH-1:0]              mem_be_o,
  input  logic                             mem_gnt_i,
  output logic                             busy_o,
  output logic [$clog2(NUM_REQ)-1:0]       owner_o
`ifdef ST_ARB_TIMEOUT_EN
  ,
  output logic                             err_o
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, REQ} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;

  logic                    found;
  logic [IDX_W-1:0]        sel;
  logic [IDX_W-1:0]        cand;
  logic [IDX_W-1:0]        owner_next;

`ifdef ST_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
`endif

  // Search from rr_ptr upward, wrapping, for the first valid requester.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Explicit wrap keeps this correct for NUM_REQ that is not a power of two.
  assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    req_gnt_o = '0;
    mem_req_o = 1'b0;
    busy_o    = 1'b0;
`ifdef ST_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          // Payload is captured here, so later requester changes cannot
          // disturb the transfer in flight.
          addr_d  = req_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          data_d  = req_data_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
          be_d    = req_be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];
          owner_d = sel;
          state_d = REQ;
`ifdef ST_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        mem_req_o = 1'b1;
        busy_o    = 1'b1;
        if (mem_gnt_i) begin
          req_gnt_o[owner_q] = 1'b1;
          rr_ptr_d           = owner_next;
          state_d            = IDLE;
        end
`ifdef ST_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the last allowed ungranted cycle: give up and move on.
          err_d    = 1'b1;
          rr_ptr_d = owner_next;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
`ifdef ST_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      be_q     <= be_d;
`ifdef ST_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign mem_be_o   = be_q;
  assign owner_o    = owner_q;
`ifdef ST_ARB_TIMEOUT_EN
  assign err_o      = err_q;
`endif

endmodule

// File: doc/st_port_arbiter.md
Name: st_port_arbiter

Overview:
- Shares the single data-cache write request port (the store unit's req_port address/data/be/grant interface) between NUM_REQ store-side requesters, e.g. store-buffer commit drain and the AMO path.
- Round-robin arbitration. The winner's payload is registered and presented to memory until the memory grant arrives, then the grant is returned to the winning requester.
- Sits between the store unit/AMO logic and the dcache write port.

Parameters:
- NUM_REQ, 2, number of requesters (>= 2)
- ADDR_WIDTH, 34, physical address width (riscv PLEN)
- DATA_WIDTH, 32, store data width (XLEN)
- BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8)
- TIMEOUT_CYCLES, 16, watchdog limit, used only with the optional feature

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  NUM_REQ  per-requester request
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed store data
- req_be_i  in  NUM_REQ*BE_WIDTH  packed byte enables
- req_gnt_o  out  NUM_REQ  one-cycle grant pulse to the winning requester
- mem_req_o  out  1  request to dcache write port
- mem_addr_o  out  ADDR_WIDTH  registered address
- mem_data_o  out  DATA_WIDTH  registered data
- mem_be_o  out  BE_WIDTH  registered byte enables
- mem_gnt_i  in  1  dcache grant; a transfer occurs when mem_req_o && mem_gnt_i
- busy_o  out  1  high while in REQ state
- owner_o  out  $clog2(NUM_REQ)  index of the current or last winner
- err_o  out  1  sticky timeout flag; present only with ST_ARB_TIMEOUT_EN

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state=IDLE, rr_ptr=0, owner_o=0.
  - mem_req_o=0, mem_addr_o/mem_data_o/mem_be_o=0, req_gnt_o=0, busy_o=0, err_o=0.
  - Reset during REQ abandons the transfer; no req_gnt_o is issued.
- FSM states: IDLE, REQ.
- IDLE:
  - If any req_valid_i is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Capture the winner's addr/data/be into the mem_* registers, set owner_o, go to REQ.
  - If no request, stay in IDLE; outputs hold their last values except mem_req_o=0.
- REQ:
  - mem_req_o=1, busy_o=1, mem_* stable.
  - When mem_gnt_i=1: req_gnt_o[owner]=1 combinationally in that same cycle, rr_ptr <= (owner+1) mod NUM_REQ, next state IDLE.
  - Otherwise stay in REQ.
- Latency:
  - req_valid_i rising in cycle N gives mem_req_o in cycle N+1.
  - Earliest req_gnt_o is cycle N+1.
  - Back-to-back transfers have a one-cycle IDLE bubble, so the maximum rate is one transfer every 2 cycles.
- Requester rule: hold valid and payload until req_gnt_o. Because the payload is captured at selection, later payload changes do not affect the in-flight transfer.
- A requester that drops valid while owning REQ still receives its grant pulse. The transfer completes; the arbiter never cancels.
- req_gnt_o is never asserted in IDLE, and at most one bit is set.
- mem_gnt_i while in IDLE is ignored.
- rr_ptr wraps from NUM_REQ-1 to 0; owner_o is not reset on return to IDLE.

Optional Feature:
- Macro: ST_ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter is cleared on entry to REQ and increments every REQ cycle without mem_gnt_i.
  - When the counter reaches TIMEOUT_CYCLES, set err_o (sticky until rst_i), drop to IDLE without granting, and advance rr_ptr past the owner.
  - err_o port exists.
- When undefined: no counter and no err_o port; REQ waits indefinitely for mem_gnt_i.

Test Plan:
- Single request, immediate grant:
  - Stimulus: reset, then req_valid_i=2'b01 with addr=34'h0_1234_5678, data=32'hDEADBEEF, be=4'hF; mem_gnt_i=1 constantly.
  - Response: mem_req_o=1 one cycle after valid with those values; req_gnt_o=2'b01 in the same cycle; owner_o=0.
- Round-robin fairness:
  - Stimulus: both requesters valid continuously, mem_gnt_i=1.
  - Response: grants alternate 01, 10, 01, 10 every 2 cycles; rr_ptr wraps 1 to 0.
- Stalled grant:
  - Stimulus: req 1 only; mem_gnt_i=0 for 5 cycles, then 1.
  - Response: mem_req_o/mem_addr_o stable for 6 cycles; req_gnt_o=2'b10 exactly once; busy_o falls the next cycle.
- Payload change and valid drop mid-REQ:
  - Stimulus: requester changes data to 32'h0 and drops valid while mem_gnt_i=0; grant later.
  - Response: mem_data_o stays 32'hDEADBEEF; the grant pulse is still issued.
- Reset mid-transfer:
  - Stimulus: rst_i=1 during REQ.
  - Response: next cycle mem_req_o=0, busy_o=0, no req_gnt_o; the next arbitration starts from requester 0.
- Timeout (with ST_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: mem_gnt_i held 0.
  - Response: after 16 REQ cycles err_o=1 (sticky), state returns to IDLE, no req_gnt_o.
